// File: rtl/calc_pkg.sv
// Shared state encoding and token codes for the calculator control path.
package calc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        EVAL,
        RESULT,
        ERROR
    } seq_state_t;

    localparam logic [7:0] TOK_DIGIT_MAX = 8'd9;
    localparam logic [7:0] TOK_ADD       = 8'd10;
    localparam logic [7:0] TOK_SUB       = 8'd11;
    localparam logic [7:0] TOK_DOT       = 8'd16;
    localparam logic [7:0] TOK_E         = 8'd17;

    function automatic logic isDigit(input logic [7:0] code);
        return code <= TOK_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Keypad, dataStructure, numBuilder and evaluator signals seen by calc_sequencer.
interface calc_sequencer_if #(
    parameter int buttons = 26,
    parameter int depth   = 12,
    parameter int width   = 8
);
    localparam int CNT_W = $clog2(depth + 1);

    logic [buttons-1:0] b;
    logic               del;
    logic               ptrLeft;
    logic               ptrRight;
    logic               eval;
    logic [CNT_W-1:0]   dsCount;
    logic               dsInsert;
    logic [width-1:0]   dsCode;
    logic               dsDel;
    logic               dsLeft;
    logic               dsRight;
    logic               nbStart;
    logic               nbDone;
    logic               evStart;
    logic               evDone;
    logic               evError;
    logic               busy;
    logic               resultValid;
    logic               errFlag;

    // The sequencer drives strobes and status; everything else feeds it.
    modport master (
        input  b, del, ptrLeft, ptrRight, eval, dsCount, nbDone, evDone, evError,
        output dsInsert, dsCode, dsDel, dsLeft, dsRight, nbStart, evStart,
               busy, resultValid, errFlag
    );

    modport slave (
        output b, del, ptrLeft, ptrRight, eval, dsCount, nbDone, evDone, evError,
        input  dsInsert, dsCode, dsDel, dsLeft, dsRight, nbStart, evStart,
               busy, resultValid, errFlag
    );

endinterface

// File: rtl/key_edge_detect.sv
// Registers raw key levels once and flags rising edges (sample & ~prev).
module key_edge_detect #(
    parameter int N = 1
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic [N-1:0] i_keys,
    output logic [N-1:0] o_edges
);

    logic [N-1:0] r_sample;
    logic [N-1:0] r_prev;

    // History resets to all-ones so a key held through reset never looks like a press.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sample <= '1;
            r_prev   <= '1;
        end else begin
            r_sample <= i_keys;
            r_prev   <= r_sample;
        end
    end

    assign o_edges = r_sample & ~r_prev;

endmodule

// File: rtl/calc_sequencer.sv
// Central calculator controller: keypad edits, then numBuilder -> evaluator sequencing.
// Optional watchdog on BUILD/EVAL enabled by defining CALC_SEQ_WATCHDOG_EN.
module calc_sequencer #(
    parameter int buttons = 26,
    parameter int depth   = 12,
    parameter int width   = 8,
    parameter int TIMEOUT = 1024
) (
    input logic                clock,
    input logic                reset,
    calc_sequencer_if.master   bus
);
    import calc_pkg::*;

    localparam int KEYS  = buttons + 4;
    localparam int CNT_W = $clog2(depth + 1);

    seq_state_t         r_state;
    seq_state_t         w_nextState;
    logic               r_dsInsert, r_dsDel, r_dsLeft, r_dsRight, r_nbStart, r_evStart;
    logic [width-1:0]   r_dsCode;
    logic               w_nextInsert, w_nextDel, w_nextLeft, w_nextRight;
    logic               w_nextNbStart, w_nextEvStart;
    logic [width-1:0]   w_nextCode;
    logic [KEYS-1:0]    w_edges;
    logic [buttons-1:0] w_bEdges;
    logic               w_evalEdge, w_rightEdge, w_leftEdge, w_delEdge, w_anyEdge;
    logic               w_bHit;
    logic [width-1:0]   w_bIdx;
    logic               w_doKeys;
    logic               w_timeout;

    key_edge_detect #(.N(KEYS)) u_keyEdge (
        .i_clock (clock),
        .i_reset (reset),
        .i_keys  ({bus.b, bus.del, bus.ptrLeft, bus.ptrRight, bus.eval}),
        .o_edges (w_edges)
    );

    assign w_evalEdge  = w_edges[0];
    assign w_rightEdge = w_edges[1];
    assign w_leftEdge  = w_edges[2];
    assign w_delEdge   = w_edges[3];
    assign w_bEdges    = w_edges[KEYS-1:4];
    assign w_anyEdge   = |w_edges;

`ifdef CALC_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wdCount;

    // Counts total cycles spent waiting on the datapath across BUILD and EVAL.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdCount <= '0;
        end else if (r_state == BUILD || r_state == EVAL) begin
            r_wdCount <= r_wdCount + 1'b1;
        end else begin
            r_wdCount <= '0;
        end
    end

    assign w_timeout = (r_state == BUILD || r_state == EVAL) &&
                       (r_wdCount == WD_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_bHit = 1'b0;
        w_bIdx = '0;
        for (int i = buttons - 1; i >= 0; i--) begin
            if (w_bEdges[i]) begin
                w_bHit = 1'b1;
                w_bIdx = width'(i);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_dsInsert <= 1'b0;
            r_dsCode   <= '0;
            r_dsDel    <= 1'b0;
            r_dsLeft   <= 1'b0;
            r_dsRight  <= 1'b0;
            r_nbStart  <= 1'b0;
            r_evStart  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_dsInsert <= w_nextInsert;
            r_dsCode   <= w_nextCode;
            r_dsDel    <= w_nextDel;
            r_dsLeft   <= w_nextLeft;
            r_dsRight  <= w_nextRight;
            r_nbStart  <= w_nextNbStart;
            r_evStart  <= w_nextEvStart;
        end
    end

    // One priority chain picks at most one action, so strobes can never overlap.
    always_comb begin
        w_nextState   = r_state;
        w_nextInsert  = 1'b0;
        w_nextCode    = '0;
        w_nextDel     = 1'b0;
        w_nextLeft    = 1'b0;
        w_nextRight   = 1'b0;
        w_nextNbStart = 1'b0;
        w_nextEvStart = 1'b0;
        w_doKeys      = 1'b0;

        case (r_state)
            IDLE: w_doKeys = 1'b1;
            BUILD: begin
                if (bus.nbDone) begin
                    w_nextEvStart = 1'b1;
                    w_nextState   = EVAL;
                end else if (w_timeout) begin
                    w_nextState = ERROR;
                end
            end
            EVAL: begin
                if (bus.evDone) begin
                    w_nextState = bus.evError ? ERROR : RESULT;
                end else if (w_timeout) begin
                    w_nextState = ERROR;
                end
            end
            RESULT: begin
                if (w_anyEdge) begin
                    w_nextState = IDLE;
                    w_doKeys    = 1'b1;
                end
            end
            ERROR: begin
                if (w_delEdge) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase

        if (w_doKeys) begin
            if (w_evalEdge) begin
                if (bus.dsCount != '0) begin
                    w_nextNbStart = 1'b1;
                    w_nextState   = BUILD;
                end
            end else if (w_delEdge) begin
                w_nextDel = 1'b1;
            end else if (w_leftEdge) begin
                w_nextLeft = 1'b1;
            end else if (w_rightEdge) begin
                w_nextRight = 1'b1;
            end else if (w_bHit && bus.dsCount != CNT_W'(depth)) begin
                w_nextInsert = 1'b1;
                w_nextCode   = w_bIdx;
            end
        end
    end

    assign bus.dsInsert    = r_dsInsert;
    assign bus.dsCode      = r_dsCode;
    assign bus.dsDel       = r_dsDel;
    assign bus.dsLeft      = r_dsLeft;
    assign bus.dsRight     = r_dsRight;
    assign bus.nbStart     = r_nbStart;
    assign bus.evStart     = r_evStart;
    assign bus.busy        = (r_state == BUILD) || (r_state == EVAL);
    assign bus.resultValid = (r_state == RESULT);
    assign bus.errFlag     = (r_state == ERROR);

endmodule
